// File: rtl/matadd_scheduler.sv
// Round-robin scheduler sharing one matadd_unit between NREQ requesters.
// Accepts one job per grant, waits for done or timeout, returns result/error to the owner.
module matadd_scheduler #(
  parameter int NREQ      = 4,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_ELEMS = 256,
  localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_mat1_ptr,
  input  logic [NREQ*32-1:0] req_mat2_ptr,
  input  logic [NREQ*32-1:0] req_out_ptr,
  input  logic [NREQ*32-1:0] req_dims,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [31:0]        rsp_result,
  output logic               rsp_error,
  output logic               unit_start,
  output logic [31:0]        unit_mat1_ptr,
  output logic [31:0]        unit_mat2_ptr,
  output logic [31:0]        unit_output_ptr,
  output logic [31:0]        unit_matrix_dims,
  input  logic [31:0]        unit_result,
  input  logic               unit_done,
  input  logic               unit_ready,
  output logic               busy,
  output logic [IW-1:0]      grant_id,
  output logic [15:0]        stat_jobs,
  output logic [15:0]        stat_errors,
  output logic [1:0]         dbg_state
);

  // Handshake: a requester holds req_valid until it sees its one-cycle req_ready pulse;
  // rsp_valid is a one-cycle pulse with rsp_result/rsp_error held stable alongside it.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [TW-1:0]   timer;
  logic [IW-1:0]   win;
  logic            any;
  logic [31:0]     sel_dims;
  logic [31:0]     elems;
  logic            dims_bad;
  int              idx;

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req_valid[idx]) begin
        win = IW'(idx);
        any = 1'b1;
      end
    end
  end

  always_comb begin
    sel_dims = req_dims[int'(win)*32 +: 32];
    elems    = {16'd0, sel_dims[31:16]} * {16'd0, sel_dims[15:0]};
    dims_bad = (sel_dims[31:16] == 16'd0) || (sel_dims[15:0] == 16'd0) ||
               (elems > 32'(MAX_ELEMS));
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      rr_ptr           <= '0;
      timer            <= '0;
      req_ready        <= '0;
      rsp_valid        <= '0;
      rsp_result       <= '0;
      rsp_error        <= 1'b0;
      unit_start       <= 1'b0;
      unit_mat1_ptr    <= '0;
      unit_mat2_ptr    <= '0;
      unit_output_ptr  <= '0;
      unit_matrix_dims <= '0;
      grant_id         <= '0;
      stat_jobs        <= '0;
      stat_errors      <= '0;
    end else begin
      req_ready  <= '0;
      rsp_valid  <= '0;
      unit_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any && unit_ready) begin
            req_ready        <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            unit_mat1_ptr    <= req_mat1_ptr[int'(win)*32 +: 32];
            unit_mat2_ptr    <= req_mat2_ptr[int'(win)*32 +: 32];
            unit_output_ptr  <= req_out_ptr[int'(win)*32 +: 32];
            unit_matrix_dims <= sel_dims;
            grant_id         <= win;
            if (dims_bad) begin
              rsp_error  <= 1'b1;
              rsp_result <= '0;
              state      <= S_RESP;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          unit_start <= 1'b1;
          timer      <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // done takes priority over a timeout landing on the same cycle
          if (unit_done) begin
            rsp_result <= unit_result;
            rsp_error  <= 1'b0;
            state      <= S_RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_result <= '0;
            rsp_error  <= 1'b1;
            state      <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
          rr_ptr    <= (grant_id == IW'(NREQ - 1)) ? '0 : IW'(grant_id + 1'b1);
          if (stat_jobs != 16'hFFFF) stat_jobs <= stat_jobs + 16'd1;
          if (rsp_error && stat_errors != 16'hFFFF) stat_errors <= stat_errors + 16'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matadd_scheduler.sv
// Bench for matadd_scheduler: vector table, hand-written corner sequences and a
// randomized phase checked against an arbitration/response model.
module tb_matadd_scheduler;
  localparam int NREQ = 4;
  localparam int TO   = 16;
  localparam int MAXE = 256;
  localparam int IW   = 2;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_mat1_ptr, req_mat2_ptr, req_out_ptr, req_dims;
  logic [NREQ-1:0]    req_ready, rsp_valid;
  logic [31:0]        rsp_result;
  logic               rsp_error, unit_start;
  logic [31:0]        unit_mat1_ptr, unit_mat2_ptr, unit_output_ptr, unit_matrix_dims;
  logic [31:0]        unit_result;
  logic               unit_done, unit_ready, busy;
  logic [IW-1:0]      grant_id;
  logic [15:0]        stat_jobs, stat_errors;
  logic [1:0]         dbg_state;

  matadd_scheduler #(.NREQ(NREQ), .TIMEOUT(TO), .MAX_ELEMS(MAXE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_mat1_ptr(req_mat1_ptr), .req_mat2_ptr(req_mat2_ptr),
    .req_out_ptr(req_out_ptr), .req_dims(req_dims),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .unit_start(unit_start),
    .unit_mat1_ptr(unit_mat1_ptr), .unit_mat2_ptr(unit_mat2_ptr),
    .unit_output_ptr(unit_output_ptr), .unit_matrix_dims(unit_matrix_dims),
    .unit_result(unit_result), .unit_done(unit_done), .unit_ready(unit_ready),
    .busy(busy), .grant_id(grant_id), .stat_jobs(stat_jobs),
    .stat_errors(stat_errors), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // requester job storage
  logic [NREQ-1:0] pend;
  logic [31:0] j_m1[NREQ], j_m2[NREQ], j_o[NREQ], j_dims[NREQ], j_res[NREQ];
  int          j_dly[NREQ];

  assign req_valid = pend;
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_mat1_ptr[32*i +: 32] = j_m1[i];
      req_mat2_ptr[32*i +: 32] = j_m2[i];
      req_out_ptr[32*i +: 32]  = j_o[i];
      req_dims[32*i +: 32]     = j_dims[i];
    end
  end

  int start_cnt = 0;
  int rsp_cnt   = 0;
  always @(negedge clk) begin
    if (unit_start) start_cnt++;
    if (|rsp_valid) rsp_cnt++;
  end

  // scoreboard and model state
  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];
  int m_rr, m_jobs, m_errs;

  typedef struct {
    int          id;
    logic [31:0] dims;
    int          dly;
    logic [31:0] res;
    bit          exp_err;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_bad_dims(input logic [31:0] d);
    longint r, c;
    r = longint'(d[31:16]);
    c = longint'(d[15:0]);
    return (r == 0) || (c == 0) || (r * c > MAXE);
  endfunction

  function automatic int model_pick();
    for (int k = 0; k < NREQ; k++)
      if (pend[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  task automatic load(input int id, input logic [31:0] dims, input int dly, input logic [31:0] res);
    j_m1[id] = $urandom; j_m2[id] = $urandom; j_o[id] = $urandom;
    j_dims[id] = dims; j_dly[id] = dly; j_res[id] = res;
    pend[id] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pend = '0; unit_done = 1'b0; unit_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_rr = 0; m_jobs = 0; m_errs = 0;
    exp_q.delete();
  endtask

  // serve the next grant; expected response supplied by caller
  task automatic serve(input bit ee, input logic [31:0] er, input int el, output int got_w);
    int w, n, t, s0;
    bit bd;
    logic [32:0] e;
    w = model_pick();
    got_w = w;
    bd = model_bad_dims(j_dims[w]);
    exp_q.push_back({ee, er});
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == '0 && n < 40);
    check("grant_seen", req_ready != '0, 1);
    if (req_ready == '0) return;
    check("req_ready", req_ready, 64'(1) << w);
    check("grant_id", grant_id, w);
    check("unit_mat1_ptr", unit_mat1_ptr, j_m1[w]);
    check("unit_mat2_ptr", unit_mat2_ptr, j_m2[w]);
    check("unit_output_ptr", unit_output_ptr, j_o[w]);
    check("unit_matrix_dims", unit_matrix_dims, j_dims[w]);
    check("busy_grant", busy, 1);
    pend[w] = 1'b0;
    s0 = start_cnt;
    t = 0;
    if (!bd) begin
      @(negedge clk);
      check("start_lat", unit_start, 1);
      if (j_dly[w] < TO) begin
        repeat (j_dly[w]) begin @(negedge clk); t++; end
        unit_done = 1'b1; unit_result = j_res[w];
        @(negedge clk); t++;
        unit_done = 1'b0; unit_result = $urandom;
      end
    end
    while (rsp_valid == '0 && t < 60) begin @(negedge clk); t++; end
    check("rsp_seen", rsp_valid != '0, 1);
    check("rsp_lat", t, el);
    check("rsp_valid", rsp_valid, 64'(1) << w);
    e = exp_q.pop_front();
    check("rsp_error", rsp_error, e[32]);
    check("rsp_result", rsp_result, e[31:0]);
    check("start_count", start_cnt - s0, bd ? 0 : 1);
    m_jobs++;
    if (e[32]) m_errs++;
    check("stat_jobs", stat_jobs, m_jobs);
    check("stat_errors", stat_errors, m_errs);
    m_rr = (w + 1) % NREQ;
  endtask

  int gw, r0;
  int fair_exp[5] = '{0, 1, 2, 3, 0};
  logic [31:0] d;
  bit ee;

  initial begin
    vecs[0] = '{0, 32'h0004_0004, 2,  32'd3,      1'b0, 32'd3,      4};
    vecs[1] = '{1, 32'h0000_0010, 0,  32'd7,      1'b1, 32'd0,      1};
    vecs[2] = '{2, 32'h0011_0010, 0,  32'd7,      1'b1, 32'd0,      1};
    vecs[3] = '{3, 32'h0010_0010, 0,  32'h1111,   1'b0, 32'h1111,   2};
    vecs[4] = '{0, 32'h0100_0001, 15, 32'hABCD,   1'b0, 32'hABCD,   17};
    vecs[5] = '{1, 32'h0004_0004, 99, 32'h9,      1'b1, 32'd0,      17};
    vecs[6] = '{2, 32'h0002_0003, 1,  32'h55,     1'b0, 32'h55,     3};
    vecs[7] = '{3, 32'h0001_0000, 0,  32'h1,      1'b1, 32'd0,      1};
    vecs[8] = '{0, 32'h0010_0011, 0,  32'h1,      1'b1, 32'd0,      1};
    for (int i = 0; i < NREQ; i++) begin
      j_m1[i] = '0; j_m2[i] = '0; j_o[i] = '0; j_dims[i] = '0; j_res[i] = '0; j_dly[i] = 0;
    end
    unit_result = '0;
    do_reset();

    check("rst_ctrl", {req_ready, rsp_valid, rsp_error, unit_start, busy, grant_id, dbg_state}, 0);
    check("rst_data", unit_mat1_ptr | unit_mat2_ptr | unit_output_ptr | unit_matrix_dims | rsp_result, 0);
    check("rst_stats", {stat_jobs, stat_errors}, 0);

    // unit_done while idle must be ignored
    unit_done = 1'b1; unit_result = 32'hDEAD;
    r0 = rsp_cnt;
    repeat (2) @(negedge clk);
    unit_done = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_done_rsp", rsp_cnt - r0, 0);
    check("idle_done_busy", busy, 0);

    // vector table
    foreach (vecs[v]) begin
      load(vecs[v].id, vecs[v].dims, vecs[v].dly, vecs[v].res);
      serve(vecs[v].exp_err, vecs[v].exp_res, vecs[v].exp_lat, gw);
      check("vec_grant", gw, vecs[v].id);
      if (v == 2) check("stat_errors_bad_dims", stat_errors, 2);
    end

    // unit not ready blocks grants
    unit_ready = 1'b0;
    load(1, 32'h0002_0002, 1, 32'h77);
    repeat (5) @(negedge clk);
    check("not_ready_grant", req_ready, 0);
    check("not_ready_busy", busy, 0);
    unit_ready = 1'b1;
    serve(1'b0, 32'h77, 3, gw);

    // fairness: all requesters held valid, requester 0 re-requests after service
    do_reset();
    for (int i = 0; i < NREQ; i++) load(i, 32'h0003_0003, 0, 32'(100 + i));
    for (int k = 0; k < 5; k++) begin
      int w;
      w = model_pick();
      serve(1'b0, j_res[w], 2, gw);
      check("fair_order", gw, fair_exp[k]);
      if (k == 0) load(0, 32'h0003_0003, 0, 32'd200);
    end

    // reset during WAIT aborts without a response
    load(2, 32'h0002_0002, 100, 32'h1);
    r0 = 0;
    while (req_ready == '0 && r0 < 40) begin @(negedge clk); r0++; end
    pend = '0;
    @(negedge clk);
    check("mid_start", unit_start, 1);
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1);
    r0 = rsp_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ctrl", {req_ready, rsp_valid, rsp_error, unit_start, busy, grant_id, dbg_state}, 0);
    check("mid_rst_data", unit_mat1_ptr | unit_matrix_dims | rsp_result | {stat_jobs, stat_errors}, 0);
    rst_n = 1'b1;
    m_rr = 0; m_jobs = 0; m_errs = 0;
    repeat (20) @(negedge clk);
    check("mid_no_rsp", rsp_cnt - r0, 0);

    // randomized phase
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          d = {16'($urandom_range(0, 20)), 16'($urandom_range(0, 20))};
          load(i, d, ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5), $urandom);
        end
      end
      if (pend == '0) load($urandom_range(0, NREQ - 1), 32'h0001_0001, 0, $urandom);
      begin
        int w;
        w = model_pick();
        if (model_bad_dims(j_dims[w])) serve(1'b1, 32'd0, 1, gw);
        else if (j_dly[w] >= TO)       serve(1'b1, 32'd0, TO + 1, gw);
        else                           serve(1'b0, j_res[w], j_dly[w] + 2, gw);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
